ldm_stm_seq: RTL and testbench

- Sequencer for block data transfers (LDM/STM). Accepts one decoded multiple-transfer instruction and drives the memory address calculator's control inputs: multiple-transfer enable, start strobe, {P,U} function code and first offset.
- Emits one register index per cycle, stalls the front pipeline during the burst, and flags base writeback on the final transfer.
- Sits between decode/issue and the memory-address stage.

---
 rtl/ldm_stm_seq.sv | 168 ++++++++++++++++
 tb/tb_ldm_stm_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: emits one register index per cycle and drives the
// address calculator controls. Optional define LDM_STM_PC_LOAD_EN adds pc_load_out.
module ldm_stm_seq #(
  parameter int unsigned REG_CNT = 16,
  parameter int unsigned IDX_W   = 4
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               start_in,
  input  logic [REG_CNT-1:0] reg_list_in,
  input  logic [1:0]         func_in,
  input  logic               load_in,
  input  logic               wb_in,
  input  logic               flush_in,
  output logic               ldm_stm_en_out,
  output logic               ldm_stm_start_out,
  output logic [1:0]         func_out,
  output logic [31:0]        offset_out,
  output logic [IDX_W-1:0]   reg_idx_out,
  output logic               xfer_valid_out,
  output logic               load_out,
  output logic               stall_out,
  output logic               base_wb_en_out,
  output logic               done_out
`ifdef LDM_STM_PC_LOAD_EN
  ,
  output logic               pc_load_out
`endif
);

  localparam int unsigned CntW = IDX_W + 1;

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e             state_q, state_d;
  logic [REG_CNT-1:0] list_q, list_d;
  logic [CntW-1:0]    remaining_q, remaining_d;
  logic               first_q, first_d;
  logic [1:0]         func_q, func_d;
  logic               load_q, load_d;
  logic               wb_q, wb_d;
  logic               empty_done_q, empty_done_d;

  logic               xfer;
  logic               last;
  logic               pc_load;
  logic [REG_CNT-1:0] pick_list;
  logic [IDX_W-1:0]   lo_idx, hi_idx, cur_idx;
  logic [CntW-1:0]    accept_cnt;

  function automatic logic [CntW-1:0] popcount(input logic [REG_CNT-1:0] v);
    logic [CntW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(REG_CNT); i++) begin
      c = c + CntW'(v[i]);
    end
    return c;
  endfunction

  assign xfer = (state_q == StXfer);

  // In descending mode with PC load support, R15 is held back until it is the only one left.
  always_comb begin
    pick_list = list_q;
`ifdef LDM_STM_PC_LOAD_EN
    if (!func_q[0] && (remaining_q > CntW'(1))) begin
      pick_list[REG_CNT-1] = 1'b0;
    end
`endif
  end

  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = 0; i < int'(REG_CNT); i++) begin
      if (pick_list[REG_CNT-1-i]) lo_idx = IDX_W'(REG_CNT-1-i);
      if (pick_list[i])           hi_idx = IDX_W'(i);
    end
  end

  assign cur_idx = func_q[0] ? lo_idx : hi_idx;

`ifdef LDM_STM_PC_LOAD_EN
  assign pc_load     = xfer && load_q && (cur_idx == IDX_W'(REG_CNT-1));
  assign pc_load_out = pc_load;
`else
  assign pc_load = 1'b0;
`endif

  assign last       = xfer && ((remaining_q == CntW'(1)) || pc_load);
  assign accept_cnt = popcount(reg_list_in);

  always_comb begin
    state_d      = state_q;
    list_d       = list_q;
    remaining_d  = remaining_q;
    first_d      = first_q;
    func_d       = func_q;
    load_d       = load_q;
    wb_d         = wb_q;
    empty_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_in && !flush_in) begin
          list_d      = reg_list_in;
          func_d      = func_in;
          load_d      = load_in;
          wb_d        = wb_in;
          remaining_d = accept_cnt;
          first_d     = 1'b1;
          if (accept_cnt != '0) begin
            state_d = StXfer;
          end else begin
            empty_done_d = 1'b1;
            first_d      = 1'b0;
          end
        end
      end
      StXfer: begin
        first_d = 1'b0;
        if (flush_in || last) begin
          state_d     = StIdle;
          list_d      = '0;
          remaining_d = '0;
        end else begin
          list_d[cur_idx] = 1'b0;
          remaining_d     = remaining_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= StIdle;
      list_q       <= '0;
      remaining_q  <= '0;
      first_q      <= 1'b0;
      func_q       <= 2'b00;
      load_q       <= 1'b0;
      wb_q         <= 1'b0;
      empty_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      list_q       <= list_d;
      remaining_q  <= remaining_d;
      first_q      <= first_d;
      func_q       <= func_d;
      load_q       <= load_d;
      wb_q         <= wb_d;
      empty_done_q <= empty_done_d;
    end
  end

  // Outputs depend only on registered state; flush takes effect from the next cycle.
  assign ldm_stm_en_out    = xfer;
  assign xfer_valid_out    = xfer;
  assign ldm_stm_start_out = xfer && first_q;
  assign func_out          = func_q;
  assign offset_out        = 32'd4;
  assign reg_idx_out       = xfer ? cur_idx : '0;
  assign load_out          = load_q;
  assign stall_out         = xfer && (remaining_q > CntW'(1)) && !pc_load;
  assign base_wb_en_out    = last && wb_q;
  assign done_out          = last || empty_done_q;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: per-transfer expectations queued at stimulus time and
// checked by a negedge monitor; control-level checks made inline.
module tb_ldm_stm_seq;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        start_in;
  logic [15:0] reg_list_in;
  logic [1:0]  func_in;
  logic        load_in;
  logic        wb_in;
  logic        flush_in;
  logic        ldm_stm_en_out;
  logic        ldm_stm_start_out;
  logic [1:0]  func_out;
  logic [31:0] offset_out;
  logic [3:0]  reg_idx_out;
  logic        xfer_valid_out;
  logic        load_out;
  logic        stall_out;
  logic        base_wb_en_out;
  logic        done_out;

  int checks = 0;
  int errors = 0;

  // {idx[3:0], start, stall, done, base_wb, load, func[1:0]}
  logic [10:0] exp_q[$];

  ldm_stm_seq dut (
    .clk_in           (clk),
    .reset_in         (reset_in),
    .start_in         (start_in),
    .reg_list_in      (reg_list_in),
    .func_in          (func_in),
    .load_in          (load_in),
    .wb_in            (wb_in),
    .flush_in         (flush_in),
    .ldm_stm_en_out   (ldm_stm_en_out),
    .ldm_stm_start_out(ldm_stm_start_out),
    .func_out         (func_out),
    .offset_out       (offset_out),
    .reg_idx_out      (reg_idx_out),
    .xfer_valid_out   (xfer_valid_out),
    .load_out         (load_out),
    .stall_out        (stall_out),
    .base_wb_en_out   (base_wb_en_out),
    .done_out         (done_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference order: ascending for U=1, descending for U=0; at most 'limit' records queued.
  task automatic push_exp(input logic [15:0] list, input logic [1:0] func, input logic load,
                          input logic wb, input int limit);
    int ord[$];
    int n;
    for (int i = 0; i < 16; i++) begin
      if (func[0] && list[i]) ord.push_back(i);
      if (!func[0] && list[15-i]) ord.push_back(15 - i);
    end
    n = ord.size();
    for (int k = 0; k < n && k < limit; k++) begin
      exp_q.push_back({4'(ord[k]), k == 0, k < n - 1, k == n - 1, wb && (k == n - 1),
                       load, func});
    end
  endtask

  always @(negedge clk) begin
    if (reset_in === 1'b0 && xfer_valid_out === 1'b1) begin
      chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("xfer_record", 32'({reg_idx_out, ldm_stm_start_out, stall_out, done_out,
                                base_wb_en_out, load_out, func_out}), 32'(exp_q.pop_front()));
        chk("xfer_en", 32'(ldm_stm_en_out), 32'd1);
      end
    end
  end

  function automatic logic [31:0] idle_vec();
    return 32'({ldm_stm_en_out, ldm_stm_start_out, xfer_valid_out, stall_out, base_wb_en_out,
                done_out, load_out, func_out, reg_idx_out});
  endfunction

  // Called at a negedge in IDLE; returns at the first IDLE negedge after done.
  task automatic run_burst(input logic [15:0] list, input logic [1:0] func, input logic load,
                           input logic wb);
    int n;
    int cyc;
    n = $countones(list);
    start_in = 1'b1; reg_list_in = list; func_in = func; load_in = load; wb_in = wb;
    push_exp(list, func, load, wb, 16);
    @(negedge clk);
    start_in = 1'b0;
    chk("first_cycle_start", 32'({xfer_valid_out, ldm_stm_start_out}), 32'b11);
    cyc = 1;
    while (done_out !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("burst_length", 32'(cyc), 32'(n));
    @(negedge clk);
    chk("idle_after_burst", 32'({ldm_stm_en_out, done_out}), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset_in = 1'b1; start_in = 1'b0; reg_list_in = '0; func_in = 2'b00;
    load_in = 1'b0; wb_in = 1'b0; flush_in = 1'b0;
    #3;
    chk("reset_outputs", idle_vec(), 32'd0);
    chk("reset_offset", offset_out, 32'd4);
    @(negedge clk);
    reset_in = 1'b0;
    @(negedge clk);

    run_burst(16'h0013, 2'b01, 1'b0, 1'b1);
    run_burst(16'h8005, 2'b10, 1'b1, 1'b0);
    run_burst(16'h0100, 2'b11, 1'b1, 1'b1);

    // Empty list: done one cycle after start, never enabled.
    start_in = 1'b1; reg_list_in = 16'h0000; func_in = 2'b01;
    @(negedge clk);
    start_in = 1'b0;
    chk("empty_done", 32'({done_out, ldm_stm_en_out, base_wb_en_out}), 32'b100);
    @(negedge clk);
    chk("empty_done_pulse", 32'({done_out, ldm_stm_en_out}), 32'd0);

    // Flush concurrent with start in IDLE: nothing accepted.
    start_in = 1'b1; flush_in = 1'b1; reg_list_in = 16'h0003; func_in = 2'b01;
    @(negedge clk);
    start_in = 1'b0; flush_in = 1'b0;
    chk("flush_beats_start", 32'({ldm_stm_en_out, done_out}), 32'd0);
    @(negedge clk);
    chk("flush_beats_start_2", 32'({ldm_stm_en_out, done_out}), 32'd0);

    // Flush on the 2nd transfer cycle of a 4-register burst.
    start_in = 1'b1; reg_list_in = 16'h00F0; func_in = 2'b01; load_in = 1'b1; wb_in = 1'b1;
    push_exp(16'h00F0, 2'b01, 1'b1, 1'b1, 2);
    @(negedge clk);
    start_in = 1'b0;
    @(negedge clk);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    chk("flush_aborts", 32'({ldm_stm_en_out, done_out, base_wb_en_out}), 32'd0);
    chk("flush_queue", 32'(exp_q.size()), 32'd0);
    run_burst(16'h0003, 2'b11, 1'b0, 1'b1);

    // Asynchronous reset between edges in the middle of a burst.
    start_in = 1'b1; reg_list_in = 16'h0F00; func_in = 2'b11; load_in = 1'b1; wb_in = 1'b1;
    push_exp(16'h0F00, 2'b11, 1'b1, 1'b1, 16);
    @(negedge clk);
    start_in = 1'b0;
    @(negedge clk);
    #2;
    reset_in = 1'b1;
    #1;
    chk("async_reset_outputs", idle_vec(), 32'd0);
    chk("async_reset_offset", offset_out, 32'd4);
    exp_q.delete();
    @(negedge clk);
    reset_in = 1'b0;
    @(negedge clk);
    run_burst(16'h0013, 2'b00, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
